// File: rtl/snake_dir_ctrl.sv
// rtl/snake_dir_ctrl.sv - snake heading control: key/IR request merge, 2-deep turn queue, pause
// One turn is applied per step tick; reversals and no-op turns never enter the queue.
module snake_dir_ctrl #(
    parameter logic [7:0] CODE_UP    = 8'h18,
    parameter logic [7:0] CODE_DOWN  = 8'h52,
    parameter logic [7:0] CODE_LEFT  = 8'h08,
    parameter logic [7:0] CODE_RIGHT = 8'h5A,
    parameter logic [7:0] CODE_PAUSE = 8'h1C
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic [3:0] key_pulse,
    input  logic       ir_data_en,
    input  logic       ir_repeat_en,
    input  logic [7:0] ir_data,
    input  logic       step_tick,
    input  logic       game_over,
    output logic [1:0] dir,
    output logic       paused,
    output logic [1:0] q_level,
    output logic       cmd_drop
);

    logic [1:0] mem [2];
    logic       rd_ptr;
    logic       wr_ptr;
    logic [1:0] count;

    logic       req_valid;
    logic [1:0] req_dir;
    logic       pause_req;
    logic [1:0] ref_dir;
    logic       reject;
    logic       pop;
    logic       accept;
    logic       push;
    logic       drop;
    logic       toggle;

    // Repeat codes carry no command byte, so they cannot change the heading.
    logic unused_repeat;
    assign unused_repeat = ir_repeat_en;

    always_comb begin
        req_valid = 1'b0;
        req_dir   = 2'b00;
        pause_req = 1'b0;
        if (|key_pulse) begin
            req_valid = 1'b1;
            if (key_pulse[3])      req_dir = 2'b00;
            else if (key_pulse[2]) req_dir = 2'b01;
            else if (key_pulse[1]) req_dir = 2'b10;
            else                   req_dir = 2'b11;
        end else if (ir_data_en) begin
            case (ir_data)
                CODE_UP:    begin req_valid = 1'b1; req_dir = 2'b00; end
                CODE_DOWN:  begin req_valid = 1'b1; req_dir = 2'b01; end
                CODE_LEFT:  begin req_valid = 1'b1; req_dir = 2'b10; end
                CODE_RIGHT: begin req_valid = 1'b1; req_dir = 2'b11; end
                CODE_PAUSE: pause_req = 1'b1;
                default:    ;
            endcase
        end
    end

    // Turns are judged against the last queued heading, i.e. where the snake will be going.
    assign ref_dir = (count != 2'd0) ? mem[~wr_ptr] : dir;
    assign reject  = (req_dir == ref_dir) || (req_dir == (ref_dir ^ 2'b01));
    assign pop     = step_tick && !paused && !game_over && (count != 2'd0);
    assign accept  = req_valid && !reject && !paused && !game_over;
    assign push    = accept && ((count != 2'd2) || pop);
    assign drop    = accept && (count == 2'd2) && !pop;
    assign toggle  = pause_req && !game_over;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            dir      <= 2'b11;
            paused   <= 1'b0;
            cmd_drop <= 1'b0;
            count    <= 2'd0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            mem[0]   <= 2'b00;
            mem[1]   <= 2'b00;
        end else begin
            cmd_drop <= drop;
            if (pop) begin
                dir    <= mem[rd_ptr];
                rd_ptr <= ~rd_ptr;
            end
            if (push) begin
                mem[wr_ptr] <= req_dir;
                wr_ptr      <= ~wr_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: ;
            endcase
            if (game_over) begin
                paused <= 1'b0;
                count  <= 2'd0;
                rd_ptr <= 1'b0;
                wr_ptr <= 1'b0;
            end else if (toggle) begin
                paused <= ~paused;
                // Entering pause discards any turns typed before it.
                if (!paused) begin
                    count  <= 2'd0;
                    rd_ptr <= 1'b0;
                    wr_ptr <= 1'b0;
                end
            end
        end
    end

    assign q_level = count;

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// tb/tb_snake_dir_ctrl.sv - scoreboard bench for snake_dir_ctrl
module tb_snake_dir_ctrl;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic [3:0] key_pulse = 4'b0000;
    logic       ir_data_en = 1'b0;
    logic       ir_repeat_en = 1'b0;
    logic [7:0] ir_data = 8'h00;
    logic       step_tick = 1'b0;
    logic       game_over = 1'b0;
    logic [1:0] dir;
    logic       paused;
    logic [1:0] q_level;
    logic       cmd_drop;

    snake_dir_ctrl dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .key_pulse    (key_pulse),
        .ir_data_en   (ir_data_en),
        .ir_repeat_en (ir_repeat_en),
        .ir_data      (ir_data),
        .step_tick    (step_tick),
        .game_over    (game_over),
        .dir          (dir),
        .paused       (paused),
        .q_level      (q_level),
        .cmd_drop     (cmd_drop)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        int         tgt;
        string      name;
        logic [1:0] dir;
        logic       paused;
        logic [1:0] q;
        logic       drop;
    } exp_t;

    exp_t exp_q[$];
    int   cnt = 0;
    int   checks = 0;
    int   errors = 0;
    logic rst_v = 1'b1;
    logic rep_v = 1'b0;

    localparam logic [3:0] K_NO = 4'b0000;
    localparam logic [3:0] K_UP = 4'b1000;
    localparam logic [3:0] K_DN = 4'b0100;
    localparam logic [3:0] K_LT = 4'b0010;
    localparam logic [3:0] K_RT = 4'b0001;

    always @(posedge sys_clk) cnt <= cnt + 1;

    // Monitor: compares registered outputs against the expectation targeted at this edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge sys_clk);
            #2;
            while (exp_q.size() > 0 && exp_q[0].tgt < cnt) begin
                e = exp_q.pop_front();
                checks++;
                errors++;
                $display("FAIL %s: expectation for cycle %0d was never compared (now %0d)", e.name, e.tgt, cnt);
            end
            if (exp_q.size() > 0 && exp_q[0].tgt == cnt) begin
                e = exp_q.pop_front();
                checks++;
                if (dir !== e.dir || paused !== e.paused || q_level !== e.q || cmd_drop !== e.drop) begin
                    errors++;
                    $display("FAIL %s: got dir=%b paused=%b q_level=%0d cmd_drop=%b, expected dir=%b paused=%b q_level=%0d cmd_drop=%b",
                             e.name, dir, paused, q_level, cmd_drop, e.dir, e.paused, e.q, e.drop);
                end
            end
        end
    end

    task automatic cyc(input string nm, input logic [3:0] k, input logic ien, input logic [7:0] ib,
                       input logic t, input logic go, input logic [1:0] ed, input logic ep,
                       input logic [1:0] eq, input logic edrop);
        exp_t e;
        @(posedge sys_clk);
        #1;
        sys_rst      = rst_v;
        key_pulse    = k;
        ir_data_en   = ien;
        ir_data      = ib;
        ir_repeat_en = rep_v;
        step_tick    = t;
        game_over    = go;
        e.tgt = cnt + 1;
        e.name = nm;
        e.dir = ed;
        e.paused = ep;
        e.q = eq;
        e.drop = edrop;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge sys_clk);
        #3;
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        // reset
        rst_v = 1'b1;
        cyc("reset0", K_NO, 0, 8'h00, 0, 0, 2'b11, 0, 0, 0);
        cyc("reset1", K_NO, 0, 8'h00, 1, 0, 2'b11, 0, 0, 0);
        rst_v = 1'b0;
        // basic push and pop
        cyc("push_up",    K_UP, 0, 8'h00, 0, 0, 2'b11, 0, 1, 0);
        cyc("tick_up",    K_NO, 0, 8'h00, 1, 0, 2'b00, 0, 0, 0);
        cyc("push_right", K_RT, 0, 8'h00, 0, 0, 2'b00, 0, 1, 0);
        cyc("tick_right", K_NO, 0, 8'h00, 1, 0, 2'b11, 0, 0, 0);
        cyc("tick_empty", K_NO, 0, 8'h00, 1, 0, 2'b11, 0, 0, 0);
        // rejects
        cyc("rev_left",   K_LT, 0, 8'h00, 0, 0, 2'b11, 0, 0, 0);
        cyc("ir_noop",    K_NO, 1, 8'h5A, 0, 0, 2'b11, 0, 0, 0);
        cyc("ir_unknown", K_NO, 1, 8'h77, 0, 0, 2'b11, 0, 0, 0);
        rep_v = 1'b1;
        cyc("ir_repeat",  K_NO, 0, 8'h18, 0, 0, 2'b11, 0, 0, 0);
        rep_v = 1'b0;
        // reference follows queue tail; priority; key beats IR
        cyc("ir_up",      K_NO, 1, 8'h18, 0, 0, 2'b11, 0, 1, 0);
        cyc("down_vs_up", K_DN, 0, 8'h00, 0, 0, 2'b11, 0, 1, 0);
        cyc("prio_dn_lt", 4'b0110, 0, 8'h00, 0, 0, 2'b11, 0, 1, 0);
        cyc("key_vs_ir",  K_DN, 1, 8'h08, 0, 0, 2'b11, 0, 1, 0);
        // full queue
        cyc("push_left",  K_LT, 0, 8'h00, 0, 0, 2'b11, 0, 2, 0);
        cyc("full_drop",  K_DN, 0, 8'h00, 0, 0, 2'b11, 0, 2, 1);
        cyc("drop_clr",   K_NO, 0, 8'h00, 0, 0, 2'b11, 0, 2, 0);
        cyc("push_pop",   K_DN, 0, 8'h00, 1, 0, 2'b00, 0, 2, 0);
        cyc("pop_left",   K_NO, 0, 8'h00, 1, 0, 2'b10, 0, 1, 0);
        cyc("refill",     K_LT, 0, 8'h00, 0, 0, 2'b10, 0, 2, 0);
        // pause
        cyc("pause_on",   K_NO, 1, 8'h1C, 0, 0, 2'b10, 1, 0, 0);
        cyc("pause_tick", K_NO, 0, 8'h00, 1, 0, 2'b10, 1, 0, 0);
        cyc("pause_key",  K_UP, 0, 8'h00, 0, 0, 2'b10, 1, 0, 0);
        cyc("pause_off",  K_NO, 1, 8'h1C, 0, 0, 2'b10, 0, 0, 0);
        cyc("pause_on2",  K_NO, 1, 8'h1C, 0, 0, 2'b10, 1, 0, 0);
        // game over
        cyc("go_unpause", K_NO, 0, 8'h00, 0, 1, 2'b10, 0, 0, 0);
        cyc("go_key",     K_UP, 0, 8'h00, 0, 1, 2'b10, 0, 0, 0);
        cyc("go_pause",   K_NO, 1, 8'h1C, 0, 1, 2'b10, 0, 0, 0);
        cyc("go_tick",    K_NO, 0, 8'h00, 1, 1, 2'b10, 0, 0, 0);
        cyc("go_resume",  K_DN, 0, 8'h00, 0, 0, 2'b10, 0, 1, 0);
        cyc("go_flush",   K_NO, 0, 8'h00, 0, 1, 2'b10, 0, 0, 0);
        cyc("go_idle",    K_NO, 0, 8'h00, 0, 0, 2'b10, 0, 0, 0);
        cyc("push_up2",   K_UP, 0, 8'h00, 0, 0, 2'b10, 0, 1, 0);
        cyc("tick_up2",   K_NO, 0, 8'h00, 1, 0, 2'b00, 0, 0, 0);
        cyc("push_rt2",   K_RT, 0, 8'h00, 0, 0, 2'b00, 0, 1, 0);
        cyc("idle_pre",   K_NO, 0, 8'h00, 0, 0, 2'b00, 0, 1, 0);
        drain();
        // asynchronous reset mid-run
        @(negedge sys_clk);
        rst_v = 1'b1;
        sys_rst = 1'b1;
        #1;
        checks++;
        if (dir !== 2'b11 || q_level !== 2'd0 || paused !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got dir=%b q_level=%0d paused=%b, expected dir=11 q_level=0 paused=0",
                     dir, q_level, paused);
        end
        cyc("rst_hold",   K_UP, 0, 8'h00, 1, 0, 2'b11, 0, 0, 0);
        rst_v = 1'b0;
        cyc("rst_rel",    K_NO, 0, 8'h00, 1, 0, 2'b11, 0, 0, 0);
        cyc("rst_idle",   K_NO, 0, 8'h00, 0, 0, 2'b11, 0, 0, 0);
        drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
